// File: rtl/vga_cmd_queue_pkg.sv
// Shared VGA controller definitions (package vga_pkg).
// Holds the CPU-visible register-select codes, the command width and the
// packed command layout {reg[10:8], data[7:0]} used by the write queue.
package vga_pkg;

    localparam logic [2:0] CTRL_REG      = 3'd0;
    localparam logic [2:0] ADDR_LOW_REG  = 3'd1;
    localparam logic [2:0] ADDR_HIGH_REG = 3'd2;
    localparam logic [2:0] DATA_REG      = 3'd3;
    localparam logic [2:0] IEN_REG       = 3'd4;
    localparam logic [2:0] INTR_REG      = 3'd5;
    localparam logic [2:0] HSCROLL_REG   = 3'd6;
    localparam logic [2:0] VSCROLL_REG   = 3'd7;

    localparam int CMD_W = 11;

    // Field order gives the packed layout {regsel[10:8], data[7:0]}.
    typedef struct packed {
        logic [2:0] regsel;
        logic [7:0] data;
    } cmd_t;

    function automatic cmd_t make_cmd(input logic [2:0] regsel, input logic [7:0] data);
        cmd_t c;
        c.regsel = regsel;
        c.data   = data;
        return c;
    endfunction

endpackage

// File: rtl/vga_cmd_queue_if.sv
// Command handshake between the CPU write queue and the register/framebuffer
// write state machine.
//   cmd_valid : head command available (producer -> consumer)
//   cmd_ready : consumer accepts the head command (consumer -> producer)
//   cmd_reg   : head command register select
//   cmd_data  : head command data
// Handshake: a command transfers on every rising CLK_FAST edge where
// cmd_valid and cmd_ready are both 1. While cmd_valid is 1 and cmd_ready is 0
// the producer holds cmd_reg/cmd_data stable; cmd_valid never drops without a
// transfer except on reset. The consumer may raise cmd_ready at any time.
interface vga_cmd_queue_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_reg;
    logic [7:0] cmd_data;

    modport master (output cmd_valid, output cmd_reg, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_reg, input cmd_data, output cmd_ready);
endinterface

// File: rtl/vga_cmd_queue_bit_sync.sv
// Single-bit synchronizer: STAGES flops in series on clk.
//   clk, rst : clock and synchronous active-high reset
//   d        : asynchronous input
//   q        : synchronized output, RST_VAL while in reset
module bit_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{RST_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/vga_cmd_queue.sv
// CPU-bus front end of the VGA controller. Samples the asynchronous 6502 bus
// in the CLK_FAST domain, detects completed register writes and queues them
// as {REG, DATA} commands for the downstream write state machine.
//   CLK_FAST, RESET            : clock, synchronous active-high reset
//   CLK_CPU, EN, RW, REG, DATA : asynchronous 6502 bus (EN active low, RW 0 = write)
//   cmd                        : head-of-queue valid/ready handshake (master side)
//   count, full                : occupancy 0..2**DEPTH_LOG2, and count at maximum
//   overflow, clear_overflow   : sticky dropped-write flag and its clear
module vga_cmd_queue
    import vga_pkg::*;
#(
    parameter int DEPTH_LOG2  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK_FAST,
    input  logic                  RESET,
    input  logic                  CLK_CPU,
    input  logic                  EN,
    input  logic                  RW,
    input  logic [2:0]            REG,
    input  logic [7:0]            DATA,
    vga_cmd_queue_if.master       cmd,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  overflow,
    input  logic                  clear_overflow
);

    localparam int                  DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic clk_s, en_s, rw_s, clk_d;
    logic wr_q, fall, wr_pend;
    logic push, pop, push_ok;
    cmd_t shadow, head;

    cmd_t                  mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;

    // Reset values model an idle bus: PHI2 low, deselected, read.
    bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
        .clk(CLK_FAST), .rst(RESET), .d(CLK_CPU), .q(clk_s)
    );
    bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_en (
        .clk(CLK_FAST), .rst(RESET), .d(EN), .q(en_s)
    );
    bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rw (
        .clk(CLK_FAST), .rst(RESET), .d(RW), .q(rw_s)
    );

    // REG/DATA are only looked at while the synchronized controls say a write
    // is in its PHI2-high phase; by then the bus value has long settled.
    assign wr_q = clk_s & ~en_s & ~rw_s;
    assign fall = clk_d & ~clk_s;
    assign push = fall & wr_pend;

    always_ff @(posedge CLK_FAST) begin
        if (RESET) begin
            clk_d   <= 1'b0;
            wr_pend <= 1'b0;
            shadow  <= '0;
        end else begin
            clk_d <= clk_s;
            if (wr_q) begin
                shadow <= make_cmd(REG, DATA);
            end
            // wr_q is 0 whenever fall is 1, so the two never compete.
            if (fall) begin
                wr_pend <= 1'b0;
            end else if (wr_q) begin
                wr_pend <= 1'b1;
            end
        end
    end

    // A full queue still takes a push when the head leaves in the same cycle.
    assign pop     = cmd.cmd_valid & cmd.cmd_ready;
    assign push_ok = push & ((count != DEPTH_C) | pop);

    always_ff @(posedge CLK_FAST) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok) begin
            mem[wr_ptr] <= shadow;
        end
    end

    always_ff @(posedge CLK_FAST) begin
        if (RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear leaves the flag set.
            if (push & ~push_ok) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    assign head          = mem[rd_ptr];
    assign cmd.cmd_valid = (count != '0);
    assign cmd.cmd_reg   = head.regsel;
    assign cmd.cmd_data  = head.data;
    assign full          = (count == DEPTH_C);

endmodule
